// File: rtl/vga_scan_ctrl.sv
// Raster scan timing for 640x480@60 VGA: pixel-tick divider, h/v counters,
// registered sync/video/frame outputs, and vblank-only access arbitration.
module vga_scan_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned HD      = 640,
  parameter int unsigned HF      = 16,
  parameter int unsigned HB      = 48,
  parameter int unsigned HR      = 96,
  parameter int unsigned VD      = 480,
  parameter int unsigned VF      = 10,
  parameter int unsigned VB      = 33,
  parameter int unsigned VR      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       upd_req,
  output logic       upd_grant,
  output logic       upd_overrun,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       pix_tick,
  output logic       h_sync,
  output logic       v_sync,
  output logic       video_on,
  output logic       vblank,
  output logic       frame_start
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(HD + HF + HB + HR - 1);
  localparam logic [9:0] V_LAST  = 10'(VD + VF + VB + VR - 1);
  localparam logic [9:0] H_GUARD = 10'(HD + HF + HB + HR - 8);
  localparam logic [9:0] H_DISP  = 10'(HD);
  localparam logic [9:0] V_DISP  = 10'(VD);
  localparam logic [9:0] HS_BEG  = 10'(HD + HF);
  localparam logic [9:0] HS_END  = 10'(HD + HF + HR);
  localparam logic [9:0] VS_BEG  = 10'(VD + VF);
  localparam logic [9:0] VS_END  = 10'(VD + VF + VR);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_HOLDOFF} arb_state_e;

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          hs_q, hs_d, vs_q, vs_d, von_q, von_d, vb_q, vb_d;
  logic          fs_q, fs_d, ovr_q, ovr_d;
  logic          tick, wrap;
  arb_state_e    st_q, st_d;

  // Flags are derived from the next counter values so they line up with
  // the counters they describe in the same cycle.
  always_comb begin
    tick  = enable && (div_q == DIV_LAST);
    wrap  = tick && (h_q == H_LAST) && (v_q == V_LAST);
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (enable) div_d = tick ? '0 : div_q + DW'(1);
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    hs_d  = !((h_d >= HS_BEG) && (h_d < HS_END));
    vs_d  = !((v_d >= VS_BEG) && (v_d < VS_END));
    von_d = (h_d < H_DISP) && (v_d < V_DISP);
    vb_d  = (v_d >= V_DISP);
    fs_d  = wrap;
  end

  always_comb begin
    st_d  = st_q;
    ovr_d = 1'b0;
    unique case (st_q)
      ST_IDLE:
        if (upd_req && vb_q && !((v_q == V_LAST) && (h_q >= H_GUARD))) st_d = ST_GRANT;
      ST_GRANT:
        if (!upd_req) begin
          st_d = ST_IDLE;
        end else if (wrap) begin
          st_d  = ST_HOLDOFF;
          ovr_d = 1'b1;
        end
      ST_HOLDOFF:
        if (!upd_req) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b1;
      vb_q  <= 1'b0;
      fs_q  <= 1'b0;
      ovr_q <= 1'b0;
      st_q  <= ST_IDLE;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      vb_q  <= vb_d;
      fs_q  <= fs_d;
      ovr_q <= ovr_d;
      st_q  <= st_d;
    end
  end

  assign pix_tick    = tick;
  assign h_count     = h_q;
  assign v_count     = v_q;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign video_on    = von_q;
  assign vblank      = vb_q;
  assign frame_start = fs_q;
  assign upd_overrun = ovr_q;
  assign upd_grant   = (st_q == ST_GRANT);

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl using a reduced raster so several
// whole frames fit in a short run; reference model counts absolute pixel ticks.
module tb_vga_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int HD = 16, HF = 4, HB = 4, HR = 6;
  localparam int VD = 8,  VF = 2, VB = 3, VR = 2;
  localparam int HTOT = HD + HF + HB + HR;
  localparam int VTOT = VD + VF + VB + VR;
  localparam int FRAME = HTOT * VTOT;
  localparam int FRAME_CLK = FRAME * CLK_DIV;
  localparam int BUDGET = 3 * FRAME_CLK;
  localparam int M_IDLE = 0, M_GRANT = 1, M_HOLD = 2;

  logic clk = 1'b0;
  logic rst_n, enable, upd_req;
  logic upd_grant, upd_overrun, pix_tick, h_sync, v_sync, video_on, vblank, frame_start;
  logic [9:0] h_count, v_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .HD(HD), .HF(HF), .HB(HB), .HR(HR),
    .VD(VD), .VF(VF), .VB(VB), .VR(VR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .upd_req(upd_req),
    .upd_grant(upd_grant), .upd_overrun(upd_overrun),
    .h_count(h_count), .v_count(v_count), .pix_tick(pix_tick),
    .h_sync(h_sync), .v_sync(v_sync), .video_on(video_on),
    .vblank(vblank), .frame_start(frame_start)
  );

  // Reference model: total pixel ticks since reset; position follows by division.
  int m_ticks, m_div, m_gst;
  logic m_ovr, m_fs;
  int mh, mv, dh, dv;
  logic e_pt, e_hs, e_vs, e_von, e_vb, e_grant;

  always_comb begin
    mh      = m_ticks % HTOT;
    mv      = (m_ticks / HTOT) % VTOT;
    dh      = int'(h_count);
    dv      = int'(v_count);
    e_pt    = enable && (m_div == CLK_DIV - 1);
    e_hs    = !(mh >= HD + HF && mh < HD + HF + HR);
    e_vs    = !(mv >= VD + VF && mv < VD + VF + VR);
    e_von   = (mh < HD) && (mv < VD);
    e_vb    = (mv >= VD);
    e_grant = (m_gst == M_GRANT);
  end

  always @(posedge clk or negedge rst_n) begin : model
    logic tk, wr;
    if (!rst_n) begin
      m_ticks <= 0; m_div <= 0; m_gst <= M_IDLE; m_ovr <= 1'b0; m_fs <= 1'b0;
    end else begin
      tk = enable && (m_div == CLK_DIV - 1);
      wr = tk && ((m_ticks + 1) % FRAME == 0);
      m_fs  <= wr;
      m_ovr <= (m_gst == M_GRANT) && upd_req && wr;
      case (m_gst)
        M_IDLE:  if (upd_req && mv >= VD && !(mv == VTOT - 1 && mh >= HTOT - 8)) m_gst <= M_GRANT;
        M_GRANT: if (!upd_req) m_gst <= M_IDLE; else if (wr) m_gst <= M_HOLD;
        default: if (!upd_req) m_gst <= M_IDLE;
      endcase
      if (enable) begin
        if (tk) begin m_div <= 0; m_ticks <= m_ticks + 1; end
        else m_div <= m_div + 1;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; upd_req = 1'b0;
    repeat (3) @(negedge clk);
    if (dh !== 0 || dv !== 0) begin $display("FAIL reset_cnt got h=%0d v=%0d want 0 0", dh, dv); bad++; end total++;
    if (h_sync !== 1'b1 || v_sync !== 1'b1) begin $display("FAIL reset_sync got hs=%b vs=%b want 1 1", h_sync, v_sync); bad++; end total++;
    if (video_on !== 1'b1 || vblank !== 1'b0) begin $display("FAIL reset_vid got von=%b vb=%b want 1 0", video_on, vblank); bad++; end total++;
    if (pix_tick !== 1'b0 || frame_start !== 1'b0) begin $display("FAIL reset_pulse got pt=%b fs=%b want 0 0", pix_tick, frame_start); bad++; end total++;
    if (upd_grant !== 1'b0 || upd_overrun !== 1'b0) begin $display("FAIL reset_arb got g=%b o=%b want 0 0", upd_grant, upd_overrun); bad++; end total++;
    rst_n = 1'b1; enable = 1'b1;
    for (int k = 1; k <= CLK_DIV; k++) begin
      @(negedge clk);
      if (pix_tick !== (k == CLK_DIV - 1)) begin $display("FAIL first_tick k=%0d got %b want %b", k, pix_tick, k == CLK_DIV - 1); bad++; end total++;
      if (dh !== ((k == CLK_DIV) ? 1 : 0)) begin $display("FAIL first_step k=%0d got h=%0d", k, dh); bad++; end total++;
      if (frame_start !== 1'b0) begin $display("FAIL fs_out_of_reset got %b want 0", frame_start); bad++; end total++;
    end
  endtask

  task automatic test_scan();
    int fs_seen = 0, last_fs = -1, hs_low = 0;
    enable = 1'b1; upd_req = 1'b0;
    for (int c = 0; c < 2 * FRAME_CLK + HTOT * CLK_DIV; c++) begin
      @(negedge clk);
      if (dh !== mh || dv !== mv) begin $display("FAIL scan_cnt got h=%0d v=%0d want h=%0d v=%0d", dh, dv, mh, mv); bad++; end total++;
      if (pix_tick !== e_pt) begin $display("FAIL scan_tick got %b want %b", pix_tick, e_pt); bad++; end total++;
      if (h_sync !== e_hs || v_sync !== e_vs) begin $display("FAIL scan_sync at h=%0d v=%0d got %b%b want %b%b", mh, mv, h_sync, v_sync, e_hs, e_vs); bad++; end total++;
      if (video_on !== e_von || vblank !== e_vb) begin $display("FAIL scan_vid at h=%0d v=%0d got %b%b want %b%b", mh, mv, video_on, vblank, e_von, e_vb); bad++; end total++;
      if (frame_start !== m_fs) begin $display("FAIL scan_fs got %b want %b", frame_start, m_fs); bad++; end total++;
      if (dh == HD - 1 && dv == VD - 1) begin
        if (video_on !== 1'b1) begin $display("FAIL von_last_pixel got %b want 1", video_on); bad++; end total++;
      end
      if (dh == HD || dv == VD) begin
        if (video_on !== 1'b0) begin $display("FAIL von_edge at h=%0d v=%0d got %b want 0", dh, dv, video_on); bad++; end total++;
      end
      if (pix_tick && !h_sync) hs_low++;
      if (pix_tick && dh == HTOT - 1) begin
        if (hs_low !== HR) begin $display("FAIL hsync_width got %0d want %0d", hs_low, HR); bad++; end total++;
        hs_low = 0;
      end
      if (frame_start) begin
        if (last_fs >= 0) begin
          if (c - last_fs !== FRAME_CLK) begin $display("FAIL frame_period got %0d want %0d", c - last_fs, FRAME_CLK); bad++; end total++;
        end
        last_fs = c; fs_seen++;
      end
    end
    if (fs_seen !== 2) begin $display("FAIL frame_count got %0d want 2", fs_seen); bad++; end total++;
  endtask

  task automatic test_vblank_grant();
    int n = 0;
    enable = 1'b1; upd_req = 1'b0;
    while (mv != 2 && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) begin $display("FAIL vbg_wait_line2 timeout"); bad++; end total++;
    upd_req = 1'b1; n = 0;
    while (mv != VD && n < BUDGET) begin
      @(negedge clk); n++;
      if (mv != VD) begin
        if (upd_grant !== 1'b0) begin $display("FAIL vbg_early_grant at v=%0d got %b want 0", mv, upd_grant); bad++; end total++;
      end
    end
    if (n >= BUDGET) begin $display("FAIL vbg_wait_vblank timeout"); bad++; end total++;
    if (vblank !== 1'b1 || upd_grant !== 1'b0) begin $display("FAIL vbg_edge got vb=%b g=%b want 1 0", vblank, upd_grant); bad++; end total++;
    @(negedge clk);
    if (upd_grant !== 1'b1) begin $display("FAIL vbg_grant_rise got %b want 1", upd_grant); bad++; end total++;
    n = 0;
    while (mv != VD + VF && n < BUDGET) begin
      @(negedge clk); n++;
      if (upd_grant !== e_grant) begin $display("FAIL vbg_hold got %b want %b", upd_grant, e_grant); bad++; end total++;
    end
    upd_req = 1'b0;
    @(negedge clk);
    if (upd_grant !== 1'b0 || upd_overrun !== 1'b0) begin $display("FAIL vbg_release got g=%b o=%b want 0 0", upd_grant, upd_overrun); bad++; end total++;
  endtask

  task automatic test_overrun();
    int n = 0, ovr_cnt = 0;
    enable = 1'b1; upd_req = 1'b0;
    while (mv != VD && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) begin $display("FAIL ovr_wait_vblank timeout"); bad++; end total++;
    upd_req = 1'b1; @(negedge clk); n = 0;
    while (!m_fs && n < BUDGET) begin
      if (upd_grant !== 1'b1) begin $display("FAIL ovr_grant_held got %b want 1", upd_grant); bad++; end total++;
      @(negedge clk); n++;
    end
    if (upd_overrun !== 1'b1 || upd_grant !== 1'b0 || frame_start !== 1'b1) begin
      $display("FAIL ovr_pulse got o=%b g=%b fs=%b want 1 0 1", upd_overrun, upd_grant, frame_start); bad++;
    end total++;
    if (dh !== 0 || dv !== 0) begin $display("FAIL ovr_wrap_pos got h=%0d v=%0d want 0 0", dh, dv); bad++; end total++;
    n = 0;
    while (mv != VD + 1 && n < BUDGET) begin
      @(negedge clk); n++;
      if (upd_overrun) ovr_cnt++;
      if (upd_grant !== 1'b0) begin $display("FAIL ovr_holdoff_grant at v=%0d got %b want 0", mv, upd_grant); bad++; end total++;
    end
    if (ovr_cnt !== 0) begin $display("FAIL ovr_extra_pulses got %0d want 0", ovr_cnt); bad++; end total++;
    upd_req = 1'b0; @(negedge clk);
    upd_req = 1'b1; @(negedge clk);
    if (upd_grant !== 1'b1 || upd_grant !== e_grant) begin $display("FAIL ovr_regrant got %b want 1", upd_grant); bad++; end total++;
    upd_req = 1'b0; @(negedge clk);
  endtask

  task automatic test_guard();
    int n = 0;
    enable = 1'b1; upd_req = 1'b0;
    while (!(mv == VTOT - 1 && mh == HTOT - 5) && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) begin $display("FAIL guard_wait timeout"); bad++; end total++;
    upd_req = 1'b1;
    for (int c = 0; c < 3 * HTOT * CLK_DIV; c++) begin
      @(negedge clk);
      if (upd_grant !== 1'b0) begin $display("FAIL guard_grant at h=%0d v=%0d got %b want 0", mh, mv, upd_grant); bad++; end total++;
    end
    upd_req = 1'b0; @(negedge clk);
  endtask

  task automatic test_freeze();
    int n = 0, sh, sv;
    enable = 1'b1; upd_req = 1'b0;
    while (!(mh == HTOT / 2 && mv == 3) && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) begin $display("FAIL frz_wait timeout"); bad++; end total++;
    sh = dh; sv = dv; enable = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (dh !== sh || dv !== sv) begin $display("FAIL frz_cnt got h=%0d v=%0d want h=%0d v=%0d", dh, dv, sh, sv); bad++; end total++;
      if (pix_tick !== 1'b0 || frame_start !== 1'b0) begin $display("FAIL frz_pulse got pt=%b fs=%b want 0 0", pix_tick, frame_start); bad++; end total++;
    end
    enable = 1'b1;
    for (int c = 0; c < HTOT * CLK_DIV; c++) begin
      @(negedge clk);
      if (dh !== mh || dv !== mv || pix_tick !== e_pt) begin
        $display("FAIL frz_resume got h=%0d v=%0d pt=%b want h=%0d v=%0d pt=%b", dh, dv, pix_tick, mh, mv, e_pt); bad++;
      end total++;
    end
  endtask

  task automatic test_arb_random();
    enable = 1'b1; upd_req = 1'b0;
    for (int c = 0; c < 4 * FRAME_CLK; c++) begin
      @(negedge clk);
      if (upd_grant !== e_grant) begin $display("FAIL rnd_grant got %b want %b", upd_grant, e_grant); bad++; end total++;
      if (upd_overrun !== m_ovr) begin $display("FAIL rnd_overrun got %b want %b", upd_overrun, m_ovr); bad++; end total++;
      if (dh !== mh || dv !== mv || pix_tick !== e_pt) begin
        $display("FAIL rnd_scan got h=%0d v=%0d pt=%b want h=%0d v=%0d pt=%b", dh, dv, pix_tick, mh, mv, e_pt); bad++;
      end total++;
      if ($urandom_range(149, 0) == 0) upd_req = ~upd_req;
      if (enable ? ($urandom_range(599, 0) == 0) : ($urandom_range(19, 0) == 0)) enable = ~enable;
    end
    enable = 1'b1; upd_req = 1'b0; @(negedge clk);
  endtask

  task automatic test_reset_mid_grant();
    int n = 0;
    enable = 1'b1; upd_req = 1'b0;
    while (mv != VD + 1 && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) begin $display("FAIL rmg_wait timeout"); bad++; end total++;
    upd_req = 1'b1; @(negedge clk); @(negedge clk);
    if (upd_grant !== 1'b1) begin $display("FAIL rmg_grant got %b want 1", upd_grant); bad++; end total++;
    @(posedge clk); #2 rst_n = 1'b0; #1;
    if (upd_grant !== 1'b0 || upd_overrun !== 1'b0) begin $display("FAIL rmg_arb got g=%b o=%b want 0 0", upd_grant, upd_overrun); bad++; end total++;
    if (dh !== 0 || dv !== 0 || pix_tick !== 1'b0 || frame_start !== 1'b0) begin
      $display("FAIL rmg_cnt got h=%0d v=%0d pt=%b fs=%b want 0 0 0 0", dh, dv, pix_tick, frame_start); bad++;
    end total++;
    if (h_sync !== 1'b1 || v_sync !== 1'b1 || video_on !== 1'b1 || vblank !== 1'b0) begin
      $display("FAIL rmg_flags got hs=%b vs=%b von=%b vb=%b want 1 1 1 0", h_sync, v_sync, video_on, vblank); bad++;
    end total++;
    repeat (3) begin
      @(negedge clk);
      if (upd_overrun !== 1'b0 || upd_grant !== 1'b0) begin $display("FAIL rmg_hold got g=%b o=%b want 0 0", upd_grant, upd_overrun); bad++; end total++;
    end
    upd_req = 1'b0; rst_n = 1'b1; @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_vblank_grant();
    test_overrun();
    test_guard();
    test_freeze();
    test_arb_random();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
